argmax_selector: RTL and testbench

ARGMAX_SELECTOR -- requirements
Module: argmax_selector

---
 rtl/argmax_pkg.sv | 21 ++
 rtl/argmax_cmp_node.sv | 44 ++++
 rtl/argmax_selector.sv | 85 ++++++++
 tb/tb_argmax_selector.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/argmax_pkg.sv
// Shared sizing helpers and defaults for the argmax compare tree.
package argmax_pkg;
  localparam int DEF_N_CLASS = 10;
  localparam int DEF_DATA_W  = 26;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int idx_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  // Surviving nodes after lvl pairwise-reduction levels.
  function automatic int nodes_at(input int n, input int lvl);
    return (n + (1 << lvl) - 1) >> lvl;
  endfunction
endpackage

// File: rtl/argmax_cmp_node.sv
// Registered two-input max node; left wins on ties so the lower index survives.
module argmax_cmp_node #(
  parameter int DATA_W = 26,
  parameter int IDX_W  = 4,
  parameter int SIGNED = 1
) (
  input  logic              clk,
  input  logic              GlobalReset,
  input  logic              en,
  input  logic              l_vld,
  input  logic [DATA_W-1:0] l_val,
  input  logic [IDX_W-1:0]  l_idx,
  input  logic              r_vld,
  input  logic [DATA_W-1:0] r_val,
  input  logic [IDX_W-1:0]  r_idx,
  output logic              vld,
  output logic [DATA_W-1:0] val,
  output logic [IDX_W-1:0]  idx
);
  logic l_wins;
  logic in_vld;

  always_comb begin
    if (SIGNED != 0) l_wins = $signed(l_val) >= $signed(r_val);
    else             l_wins = l_val >= r_val;
  end

  assign in_vld = l_vld & r_vld;

  // Value/index only load on a valid beat so outputs hold across bubbles.
  always_ff @(posedge clk or negedge GlobalReset) begin
    if (!GlobalReset) begin
      vld <= 1'b0;
      val <= '0;
      idx <= '0;
    end else if (en) begin
      vld <= in_vld;
      if (in_vld) begin
        val <= l_wins ? l_val : r_val;
        idx <= l_wins ? l_idx : r_idx;
      end
    end
  end
endmodule

// File: rtl/argmax_selector.sv
// Pipelined argmax: input register stage followed by a registered binary compare tree,
// globally stalled when the output result is not taken.
module argmax_selector
  import argmax_pkg::*;
#(
  parameter int N_CLASS = DEF_N_CLASS,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int SIGNED  = 1,
  localparam int IDX_W  = idx_w(N_CLASS)
) (
  input  logic                      clk,
  input  logic                      GlobalReset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N_CLASS*DATA_W-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [IDX_W-1:0]          out_idx,
  output logic [DATA_W-1:0]         out_max
);
  localparam int LVLS = clog2(N_CLASS);

  logic stall;
  logic en;
  logic s0_vld;
  logic [N_CLASS-1:0][DATA_W-1:0] s0_val;

  assign stall    = out_valid & ~out_ready;
  assign en       = ~stall;
  assign in_ready = en;

  always_ff @(posedge clk or negedge GlobalReset) begin
    if (!GlobalReset) begin
      s0_vld <= 1'b0;
      s0_val <= '0;
    end else if (en) begin
      s0_vld <= in_valid;
      if (in_valid) s0_val <= in_data;
    end
  end

  for (genvar l = 0; l <= LVLS; l++) begin : g_lvl
    localparam int NN = nodes_at(N_CLASS, l);
    logic [NN-1:0]             vld;
    logic [NN-1:0][DATA_W-1:0] val;
    logic [NN-1:0][IDX_W-1:0]  idx;

    if (l == 0) begin : g_in
      for (genvar k = 0; k < NN; k++) begin : g_leaf
        assign vld[k] = s0_vld;
        assign val[k] = s0_val[k];
        assign idx[k] = IDX_W'(k);
      end
    end else begin : g_tree
      localparam int NP = nodes_at(N_CLASS, l - 1);
      for (genvar k = 0; k < NN; k++) begin : g_node
        // An unpaired last node is compared against itself: left wins, so it passes through.
        localparam int LI = 2 * k;
        localparam int RI = (2 * k + 1 < NP) ? 2 * k + 1 : 2 * k;
        argmax_cmp_node #(
          .DATA_W(DATA_W),
          .IDX_W (IDX_W),
          .SIGNED(SIGNED)
        ) u_node (
          .clk        (clk),
          .GlobalReset(GlobalReset),
          .en         (en),
          .l_vld      (g_lvl[l-1].vld[LI]),
          .l_val      (g_lvl[l-1].val[LI]),
          .l_idx      (g_lvl[l-1].idx[LI]),
          .r_vld      (g_lvl[l-1].vld[RI]),
          .r_val      (g_lvl[l-1].val[RI]),
          .r_idx      (g_lvl[l-1].idx[RI]),
          .vld        (vld[k]),
          .val        (val[k]),
          .idx        (idx[k])
        );
      end
    end
  end

  assign out_valid = g_lvl[LVLS].vld[0];
  assign out_max   = g_lvl[LVLS].val[0];
  assign out_idx   = g_lvl[LVLS].idx[0];
endmodule

// File: tb/tb_argmax_selector.sv
// Directed + randomized bench for argmax_selector across N_CLASS 2/3/10/17 and both compare modes.
module tb_argmax_selector;
  localparam int W    = 26;
  localparam int NMAX = 17;
  localparam int ND   = 5;

  logic clk = 1'b0;
  logic GlobalReset;
  logic in_valid;
  logic [NMAX*W-1:0] dbus;
  logic ready_a, ready_1;

  logic a_in_ready, a_out_valid; logic [3:0] a_out_idx; logic [W-1:0] a_out_max;
  logic u_in_ready, u_out_valid; logic [3:0] u_out_idx; logic [W-1:0] u_out_max;
  logic s2_in_ready, s2_out_valid; logic [0:0] s2_out_idx; logic [W-1:0] s2_out_max;
  logic s3_in_ready, s3_out_valid; logic [1:0] s3_out_idx; logic [W-1:0] s3_out_max;
  logic s17_in_ready, s17_out_valid; logic [4:0] s17_out_idx; logic [W-1:0] s17_out_max;

  always #5 clk = ~clk;

  argmax_selector #(.N_CLASS(10), .DATA_W(W), .SIGNED(1)) u_a (
    .clk(clk), .GlobalReset(GlobalReset), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_data(dbus[10*W-1:0]), .out_valid(a_out_valid), .out_ready(ready_a),
    .out_idx(a_out_idx), .out_max(a_out_max));
  argmax_selector #(.N_CLASS(10), .DATA_W(W), .SIGNED(0)) u_u (
    .clk(clk), .GlobalReset(GlobalReset), .in_valid(in_valid), .in_ready(u_in_ready),
    .in_data(dbus[10*W-1:0]), .out_valid(u_out_valid), .out_ready(ready_1),
    .out_idx(u_out_idx), .out_max(u_out_max));
  argmax_selector #(.N_CLASS(2), .DATA_W(W), .SIGNED(1)) u_s2 (
    .clk(clk), .GlobalReset(GlobalReset), .in_valid(in_valid), .in_ready(s2_in_ready),
    .in_data(dbus[2*W-1:0]), .out_valid(s2_out_valid), .out_ready(ready_1),
    .out_idx(s2_out_idx), .out_max(s2_out_max));
  argmax_selector #(.N_CLASS(3), .DATA_W(W), .SIGNED(1)) u_s3 (
    .clk(clk), .GlobalReset(GlobalReset), .in_valid(in_valid), .in_ready(s3_in_ready),
    .in_data(dbus[3*W-1:0]), .out_valid(s3_out_valid), .out_ready(ready_1),
    .out_idx(s3_out_idx), .out_max(s3_out_max));
  argmax_selector #(.N_CLASS(17), .DATA_W(W), .SIGNED(1)) u_s17 (
    .clk(clk), .GlobalReset(GlobalReset), .in_valid(in_valid), .in_ready(s17_in_ready),
    .in_data(dbus), .out_valid(s17_out_valid), .out_ready(ready_1),
    .out_idx(s17_out_idx), .out_max(s17_out_max));

  // Per-DUT view for the sweep checker: N, compare mode, latency LAT = ceil(log2 N)+1.
  int   dn[ND]  = '{10, 10, 2, 3, 17};
  bit   dsg[ND] = '{1, 0, 1, 1, 1};
  int   dlat[ND] = '{5, 5, 2, 3, 6};
  logic ov[ND];
  logic rdy[ND];
  logic [7:0] oi[ND];
  logic [W-1:0] om[ND];
  assign ov[0] = a_out_valid;   assign oi[0] = 8'(a_out_idx);   assign om[0] = a_out_max;
  assign ov[1] = u_out_valid;   assign oi[1] = 8'(u_out_idx);   assign om[1] = u_out_max;
  assign ov[2] = s2_out_valid;  assign oi[2] = 8'(s2_out_idx);  assign om[2] = s2_out_max;
  assign ov[3] = s3_out_valid;  assign oi[3] = 8'(s3_out_idx);  assign om[3] = s3_out_max;
  assign ov[4] = s17_out_valid; assign oi[4] = 8'(s17_out_idx); assign om[4] = s17_out_max;
  assign rdy[0] = a_in_ready; assign rdy[1] = u_in_ready; assign rdy[2] = s2_in_ready;
  assign rdy[3] = s3_in_ready; assign rdy[4] = s17_in_ready;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic longint sval(input logic [W-1:0] v, input bit sgn);
    return sgn ? longint'($signed(v)) : longint'({38'b0, v});
  endfunction

  // Reference: first index holding the maximum score.
  function automatic void ref_argmax(input logic [NMAX*W-1:0] d, input int n, input bit sgn,
                                     output int bi, output logic [W-1:0] bm);
    bi = 0;
    for (int i = 1; i < n; i++)
      if (sval(d[i*W +: W], sgn) > sval(d[bi*W +: W], sgn)) bi = i;
    bm = d[bi*W +: W];
  endfunction

  function automatic logic [W-1:0] rnd_score();
    int s;
    s = $urandom_range(0, 2);
    case (s)
      0:       return W'($urandom);
      1:       return W'($urandom_range(0, 6)) - W'(3);
      default: return ($urandom_range(0, 1) != 0) ? 26'h2000000 : 26'h1FFFFFF;
    endcase
  endfunction

  function automatic logic [NMAX*W-1:0] rnd_vec(input int n);
    logic [NMAX*W-1:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[i*W +: W] = rnd_score();
    return v;
  endfunction

  // Sweep checker: inputs recorded per edge, each DUT's output after edge c must reflect edge c-LAT+1.
  int cyc = 0;
  bit sweep_chk = 0;
  logic hv[64];
  logic [NMAX*W-1:0] hd[64];

  always @(posedge clk) begin
    hv[cyc % 64] <= in_valid;
    hd[cyc % 64] <= dbus;
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (sweep_chk) begin
      for (int d = 0; d < ND; d++) begin
        int e, ri;
        logic [W-1:0] rm;
        e = cyc - dlat[d];
        chk($sformatf("sw%0d_rdy", dn[d]), rdy[d], 1'b1);
        chk($sformatf("sw%0d_s%0d_vld", dn[d], dsg[d]), ov[d], hv[e % 64]);
        if (hv[e % 64]) begin
          ref_argmax(hd[e % 64], dn[d], dsg[d], ri, rm);
          chk($sformatf("sw%0d_s%0d_idx", dn[d], dsg[d]), oi[d], ri);
          chk($sformatf("sw%0d_s%0d_max", dn[d], dsg[d]), om[d], rm);
        end
      end
    end
  end

  // One vector into the N=10 signed DUT; latency counts edges from accept edge (=1) to output edge.
  task automatic run_one(input string tag, input logic [NMAX*W-1:0] v, input int ei,
                         input logic [W-1:0] em);
    int k;
    @(negedge clk);
    dbus = v;
    in_valid = 1'b1;
    chk({tag, "_in_ready"}, a_in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    k = 1;
    while (!a_out_valid && k < 12) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_lat"}, k, 5);
    chk({tag, "_idx"}, a_out_idx, ei);
    chk({tag, "_max"}, a_out_max, em);
  endtask

  logic [NMAX*W-1:0] v;
  logic [NMAX*W-1:0] vq[8];
  int exq_i[$];
  logic [W-1:0] exq_m[$];
  int sent, got, stalls, stale, ti, wt;
  logic [W-1:0] tm;
  bit pat[6] = '{1, 0, 0, 1, 0, 1};

  initial begin
    GlobalReset = 1'b0;
    in_valid = 1'b0;
    dbus = '0;
    ready_a = 1'b0;
    ready_1 = 1'b1;
    #12;
    chk("rst_out_valid", a_out_valid, 1'b0);
    chk("rst_out_idx", a_out_idx, 0);
    chk("rst_out_max", a_out_max, 0);
    chk("rst_in_ready", a_in_ready, 1'b1);
    @(negedge clk);
    GlobalReset = 1'b1;
    ready_a = 1'b1;

    v = '0;
    for (int i = 0; i < 10; i++) v[i*W +: W] = W'(i * 100);
    v[7*W +: W] = 26'd5000;
    run_one("basic", v, 7, 26'd5000);

    v = '0;
    for (int i = 0; i < 10; i++) v[i*W +: W] = 26'h3FFFFFF;
    v[3*W +: W] = 26'h3FFFFFE;
    v[9*W +: W] = 26'h0;
    run_one("signed", v, 9, 26'h0);
    chk("unsigned_vld", u_out_valid, 1'b1);
    chk("unsigned_idx", u_out_idx, 0);
    chk("unsigned_max", u_out_max, 26'h3FFFFFF);

    v = '0;
    v[2*W +: W] = 26'h100; v[6*W +: W] = 26'h100; v[8*W +: W] = 26'h100;
    run_one("tie3", v, 2, 26'h100);

    for (int i = 0; i < 10; i++) v[i*W +: W] = 26'h0ABCDE;
    run_one("all_eq", v, 0, 26'h0ABCDE);
    @(negedge clk);
    chk("drain_vld", a_out_valid, 1'b0);
    chk("drain_hold_max", a_out_max, 26'h0ABCDE);

    // Backpressure: 8 back-to-back vectors under a 1,0,0,1,0,1 out_ready pattern.
    for (int i = 0; i < 8; i++) vq[i] = rnd_vec(10);
    sent = 0; got = 0; stalls = 0;
    for (int c = 0; c < 200 && got < 8; c++) begin
      @(negedge clk);
      ready_a = pat[c % 6];
      if (sent < 8) begin
        dbus = vq[sent];
        in_valid = 1'b1;
      end else in_valid = 1'b0;
      #1;
      chk("bp_in_ready", a_in_ready, !(a_out_valid && !ready_a));
      if (a_out_valid && !ready_a) stalls++;
      if (a_out_valid && ready_a) begin
        if (exq_i.size() == 0) chk("bp_extra", 1, 0);
        else begin
          chk("bp_idx", a_out_idx, exq_i.pop_front());
          chk("bp_max", a_out_max, exq_m.pop_front());
        end
        got++;
      end
      if (in_valid && a_in_ready) begin
        ref_argmax(vq[sent], 10, 1'b1, ti, tm);
        exq_i.push_back(ti);
        exq_m.push_back(tm);
        sent++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    ready_a = 1'b1;
    chk("bp_count", got, 8);
    chk("bp_stalls_seen", stalls > 0, 1'b1);
    repeat (3) @(negedge clk);

    // Reset with three vectors in flight and the head stalled at the output.
    ready_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      dbus = rnd_vec(10);
      in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    wt = 0;
    while (!a_out_valid && wt < 10) begin
      @(negedge clk);
      wt++;
    end
    chk("pre_rst_vld", a_out_valid, 1'b1);
    #2 GlobalReset = 1'b0;
    #1;
    chk("mid_rst_vld", a_out_valid, 1'b0);
    chk("mid_rst_idx", a_out_idx, 0);
    chk("mid_rst_max", a_out_max, 0);
    chk("mid_rst_rdy", a_in_ready, 1'b1);
    repeat (2) @(negedge clk);
    GlobalReset = 1'b1;
    ready_a = 1'b1;
    stale = 0;
    repeat (8) begin
      @(negedge clk);
      if (a_out_valid) stale++;
    end
    chk("post_rst_stale", stale, 0);
    v = '0;
    for (int i = 0; i < 10; i++) v[i*W +: W] = W'(i + 1);
    v[4*W +: W] = 26'd777;
    run_one("post_rst", v, 4, 26'd777);

    // Randomized sweep across all instances with free-flowing output.
    @(negedge clk);
    in_valid = 1'b0;
    repeat (8) @(negedge clk);
    sweep_chk = 1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      in_valid = ($urandom_range(0, 9) < 7);
      dbus = rnd_vec(NMAX);
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (8) @(negedge clk);
    sweep_chk = 0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
